// File: rtl/rtp_audio_depacketizer_pkg.sv
// Shared RTP definitions: header layout, parser states and default stream identity.
package rtp_pkg;

  localparam logic [15:0] RTP_HDR_BYTES = 16'd12;
  localparam logic [15:0] SEQ_HI        = 16'd2;
  localparam logic [15:0] SEQ_LO        = 16'd3;
  localparam logic [15:0] SSRC0         = 16'd8;

  localparam logic [15:0] RTP_HEADER_DEF = 16'h8080;
  localparam logic [31:0] SSRC_DEF       = 32'h12345678;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  // Saturating 16-bit event counter increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Big-endian SSRC byte k (k=0 is the first byte on the wire).
  function automatic logic [7:0] ssrc_byte(input logic [31:0] s, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = s[31:24];
      2'd1:    b = s[23:16];
      2'd2:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtp_audio_depacketizer_if.sv
// UDP receive byte stream plus the playback sample read port.
interface rtp_audio_depacketizer_if;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic        wav_rden;
  logic [15:0] wav_out_data;

  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    input  wav_out_data
  );

  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    output wav_out_data
  );
endinterface

// File: rtl/rtp_audio_depacketizer_fifo.sv
// Single-clock 16-bit sample FIFO with registered read data and extended-pointer level.
module sample_fifo #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [15:0]   i_din,
  input  logic          i_pop,
  output logic [15:0]   o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [15:0] r_mem [2**AW];
  logic [15:0] r_dout;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_dout  = r_dout;

  // Pointer advance; a push into a full FIFO is ignored here and counted by the parent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Sample storage with synchronous read, suitable for block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    if (w_rd_en) r_dout <= r_mem[r_rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/rtp_audio_depacketizer.sv
// RTP audio receive path: header validation, PCM unpacking into a jitter FIFO, playout.
module rtp_audio_depacketizer
  import rtp_pkg::*;
#(
  parameter logic [15:0] RTP_HEADER = RTP_HEADER_DEF,
  parameter logic [31:0] SSRC       = SSRC_DEF,
  parameter int          FIFO_AW    = 10,
  parameter int          PREFILL    = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rtp_audio_depacketizer_if.slave bus,
  output logic                 playing,
  output logic [FIFO_AW:0]     fifo_level,
  output logic [15:0]          pkt_ok_cnt,
  output logic [15:0]          pkt_drop_cnt,
  output logic [15:0]          seq_gap_cnt,
  output logic [15:0]          underrun_cnt,
  output logic [15:0]          overflow_cnt
);

  localparam logic [FIFO_AW:0] PREFILL_L = (FIFO_AW+1)'(PREFILL);

  rx_state_t   r_state, w_state_n;
  logic [15:0] r_bcnt, w_bcnt_n;
  logic [15:0] r_len;
  logic [7:0]  r_seq_hi, r_seq_lo, r_msb;
  logic [15:0] r_exp_seq;
  logic        r_seq_valid;
  logic        r_push;
  logic [15:0] r_push_data;
  logic        r_zero;
  logic        r_playing;
  logic [15:0] r_ok_cnt, r_drop_cnt, r_gap_cnt, r_under_cnt, r_ovf_cnt;

  logic        w_len_load, w_drop, w_ok, w_hdr_done, w_hdr_fail;
  logic        w_seq_hi_ld, w_seq_lo_ld, w_msb_ld, w_sample;
  logic [7:0]  w_rdata;
  logic [15:0] w_seq;
  logic [15:0] w_fifo_dout;
  logic        w_full, w_empty, w_pop;
  logic [FIFO_AW:0] w_level;

  assign w_rdata = bus.udp_rec_rdata;
  assign w_seq   = {r_seq_hi, r_seq_lo};
  assign w_pop   = bus.wav_rden && r_playing && !w_empty;

  sample_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_din   (r_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Parser state and byte counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_bcnt  <= w_bcnt_n;
    end
  end

  // Parser next state and per-byte strobes; r_bcnt is the index of the incoming byte.
  always_comb begin
    w_state_n   = r_state;
    w_bcnt_n    = r_bcnt;
    w_len_load  = 1'b0;
    w_drop      = 1'b0;
    w_ok        = 1'b0;
    w_hdr_done  = 1'b0;
    w_hdr_fail  = 1'b0;
    w_seq_hi_ld = 1'b0;
    w_seq_lo_ld = 1'b0;
    w_msb_ld    = 1'b0;
    w_sample    = 1'b0;
    if (bus.udp_rec_data_valid) begin
      w_bcnt_n = r_bcnt + 16'd1;
      case (r_state)
        ST_IDLE: begin
          w_len_load = 1'b1;
          w_bcnt_n   = 16'd1;
          if (bus.udp_rec_data_length < RTP_HDR_BYTES) begin
            w_drop    = 1'b1;
            w_state_n = (bus.udp_rec_data_length <= 16'd1) ? ST_IDLE : ST_DROP;
          end else if (w_rdata != RTP_HEADER[15:8]) begin
            w_drop    = 1'b1;
            w_state_n = ST_DROP;
          end else begin
            w_state_n = ST_HDR;
          end
        end
        ST_HDR: begin
          if (r_bcnt == 16'd1 && w_rdata != RTP_HEADER[7:0]) w_hdr_fail = 1'b1;
          if (r_bcnt >= SSRC0 && w_rdata != ssrc_byte(SSRC, r_bcnt[1:0])) w_hdr_fail = 1'b1;
          w_seq_hi_ld = (r_bcnt == SEQ_HI);
          w_seq_lo_ld = (r_bcnt == SEQ_LO);
          if (w_hdr_fail) begin
            w_drop    = 1'b1;
            w_state_n = (w_bcnt_n == r_len) ? ST_IDLE : ST_DROP;
          end else if (w_bcnt_n == RTP_HDR_BYTES) begin
            w_hdr_done = 1'b1;
            if (r_len == RTP_HDR_BYTES) begin
              w_ok      = 1'b1;
              w_state_n = ST_IDLE;
            end else begin
              w_state_n = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          // The header is an even byte count, so bcnt parity equals payload parity.
          w_msb_ld = !r_bcnt[0];
          w_sample = r_bcnt[0];
          if (w_bcnt_n == r_len) begin
            w_ok      = 1'b1;
            w_state_n = ST_IDLE;
          end
        end
        default: begin
          if (w_bcnt_n == r_len) w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Captured packet fields and assembled sample.
  always_ff @(posedge clk) begin
    if (w_len_load)  r_len       <= bus.udp_rec_data_length;
    if (w_seq_hi_ld) r_seq_hi    <= w_rdata;
    if (w_seq_lo_ld) r_seq_lo    <= w_rdata;
    if (w_msb_ld)    r_msb       <= w_rdata;
    if (w_sample)    r_push_data <= {r_msb, w_rdata};
    if (w_hdr_done)  r_exp_seq   <= w_seq + 16'd1;
  end

  // Sample push strobe, sequence tracking and packet statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_push      <= 1'b0;
      r_seq_valid <= 1'b0;
      r_ok_cnt    <= '0;
      r_drop_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      r_push <= w_sample;
      if (w_hdr_done) begin
        r_seq_valid <= 1'b1;
        if (r_seq_valid && w_seq != r_exp_seq) r_gap_cnt <= sat_inc(r_gap_cnt);
      end
      if (w_ok)            r_ok_cnt   <= sat_inc(r_ok_cnt);
      if (w_drop)          r_drop_cnt <= sat_inc(r_drop_cnt);
      if (r_push && w_full) r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end
  end

  // Playout gating: prime at the prefill level, disarm on a read from an empty FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_playing   <= 1'b0;
      r_zero      <= 1'b1;
      r_under_cnt <= '0;
    end else begin
      if (bus.wav_rden && w_empty)   r_playing <= 1'b0;
      else if (w_level >= PREFILL_L) r_playing <= 1'b1;
      if (bus.wav_rden) begin
        r_zero <= !w_pop;
        if (!w_pop) r_under_cnt <= sat_inc(r_under_cnt);
      end
    end
  end

  assign bus.wav_out_data = r_zero ? 16'h0000 : w_fifo_dout;
  assign playing          = r_playing;
  assign fifo_level       = w_level;
  assign pkt_ok_cnt       = r_ok_cnt;
  assign pkt_drop_cnt     = r_drop_cnt;
  assign seq_gap_cnt      = r_gap_cnt;
  assign underrun_cnt     = r_under_cnt;
  assign overflow_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_rtp_audio_depacketizer.sv
// Bench for rtp_audio_depacketizer: packet-level reference model plus directed packets.
module tb_rtp_audio_depacketizer;
  import rtp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  rtp_audio_depacketizer_if if_a ();
  rtp_audio_depacketizer_if if_b ();

  logic        play_a, play_b;
  logic [10:0] lvl_a;
  logic [4:0]  lvl_b;
  logic [15:0] ok_a, drop_a, gap_a, under_a, ovf_a;
  logic [15:0] ok_b, drop_b, gap_b, under_b, ovf_b;

  rtp_audio_depacketizer #(.FIFO_AW(10), .PREFILL(480)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .playing(play_a), .fifo_level(lvl_a),
    .pkt_ok_cnt(ok_a), .pkt_drop_cnt(drop_a), .seq_gap_cnt(gap_a),
    .underrun_cnt(under_a), .overflow_cnt(ovf_a)
  );

  rtp_audio_depacketizer #(.FIFO_AW(4), .PREFILL(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .playing(play_b), .fifo_level(lvl_b),
    .pkt_ok_cnt(ok_b), .pkt_drop_cnt(drop_b), .seq_gap_cnt(gap_b),
    .underrun_cnt(under_b), .overflow_cnt(ovf_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  pkt[$];
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  int m_ok[2], m_drop[2], m_gap[2], m_under[2], m_ovf[2], m_play[2], m_seqv[2], m_exp[2];
  int depth[2] = '{1024, 16};
  int pref[2]  = '{480, 8};

  function automatic int msize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    for (int d = 0; d < 2; d++) begin
      m_ok[d] = 0; m_drop[d] = 0; m_gap[d] = 0; m_under[d] = 0;
      m_ovf[d] = 0; m_play[d] = 0; m_seqv[d] = 0; m_exp[d] = 0;
    end
  endfunction

  // Whole-packet outcome: accept/reject, sequence gap, samples into the bounded queue.
  function automatic void model_pkt(input int d, input int len);
    int seq;
    int ns;
    logic [15:0] v;
    if (len < 12) begin m_drop[d]++; return; end
    if (pkt[0] != 8'h80 || pkt[1] != 8'h80 ||
        {pkt[8], pkt[9], pkt[10], pkt[11]} != 32'h12345678) begin
      m_drop[d]++;
      return;
    end
    seq = int'({pkt[2], pkt[3]});
    if (m_seqv[d] != 0 && seq != m_exp[d]) m_gap[d]++;
    m_exp[d]  = (seq + 1) % 65536;
    m_seqv[d] = 1;
    m_ok[d]++;
    ns = (len - 12) / 2;
    for (int i = 0; i < ns; i++) begin
      v = {pkt[12 + 2*i], pkt[13 + 2*i]};
      if (msize(d) < depth[d]) begin
        if (d == 0) mq0.push_back(v); else mq1.push_back(v);
      end else begin
        m_ovf[d]++;
      end
    end
    if (msize(d) >= pref[d]) m_play[d] = 1;
  endfunction

  function automatic logic [15:0] model_read(input int d);
    if (m_play[d] != 0 && msize(d) > 0) begin
      if (d == 0) return mq0.pop_front();
      return mq1.pop_front();
    end
    m_under[d]++;
    if (msize(d) == 0) m_play[d] = 0;
    return 16'h0000;
  endfunction

  // ---------------- per-cycle output comparison ----------------
  logic [15:0] exp_a = '0, last_a = '0, exp_b = '0, last_b = '0;
  bit pend_a = 1'b0, pend_b = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_a = 1'b0; last_a = '0;
      pend_b = 1'b0; last_b = '0;
    end else begin
      if (pend_a) last_a = exp_a;
      if (pend_b) last_b = exp_b;
      check("wav_out_data_a", int'(if_a.wav_out_data), int'(last_a));
      check("wav_out_data_b", int'(if_b.wav_out_data), int'(last_b));
      pend_a = if_a.wav_rden;
      pend_b = if_b.wav_rden;
      if (pend_a) exp_a = model_read(0);
      if (pend_b) exp_b = model_read(1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int d, input logic v, input logic [7:0] b);
    if (d == 0) begin if_a.udp_rec_data_valid = v; if_a.udp_rec_rdata = b; end
    else        begin if_b.udp_rec_data_valid = v; if_b.udp_rec_rdata = b; end
  endtask

  task automatic build(input int seq, input logic [31:0] ssrc, input int ns,
                       input int base, input int extra);
    logic [15:0] s16;
    logic [15:0] v;
    pkt.delete();
    s16 = 16'(seq);
    pkt.push_back(8'h80); pkt.push_back(8'h80);
    pkt.push_back(s16[15:8]); pkt.push_back(s16[7:0]);
    pkt.push_back(8'h12); pkt.push_back(8'h34); pkt.push_back(8'h56); pkt.push_back(8'h78);
    pkt.push_back(ssrc[31:24]); pkt.push_back(ssrc[23:16]);
    pkt.push_back(ssrc[15:8]);  pkt.push_back(ssrc[7:0]);
    for (int i = 0; i < ns; i++) begin
      v = 16'(base + i);
      pkt.push_back(v[15:8]);
      pkt.push_back(v[7:0]);
    end
    for (int i = 0; i < extra; i++) pkt.push_back(8'hEE);
  endtask

  task automatic send_bytes(input int d, input bit toggle, input int nbytes);
    if (d == 0) if_a.udp_rec_data_length = 16'(pkt.size());
    else        if_b.udp_rec_data_length = 16'(pkt.size());
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      drive(d, 1'b1, pkt[i]);
      if (toggle) begin @(posedge clk); #1; drive(d, 1'b0, 8'h00); end
    end
  endtask

  task automatic send(input int d, input bit toggle);
    send_bytes(d, toggle, pkt.size());
    @(posedge clk); #1;
    drive(d, 1'b0, 8'h00);
    model_pkt(d, pkt.size());
    repeat (6) @(posedge clk);
  endtask

  task automatic reads(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (d == 0) if_a.wav_rden = 1'b1; else if_b.wav_rden = 1'b1;
    end
    @(posedge clk); #1;
    if_a.wav_rden = 1'b0;
    if_b.wav_rden = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_status(input int d);
    if (d == 0) begin
      check("pkt_ok_a", int'(ok_a), m_ok[0]);
      check("pkt_drop_a", int'(drop_a), m_drop[0]);
      check("seq_gap_a", int'(gap_a), m_gap[0]);
      check("underrun_a", int'(under_a), m_under[0]);
      check("overflow_a", int'(ovf_a), m_ovf[0]);
      check("level_a", int'(lvl_a), msize(0));
      check("playing_a", int'(play_a), m_play[0]);
    end else begin
      check("pkt_ok_b", int'(ok_b), m_ok[1]);
      check("pkt_drop_b", int'(drop_b), m_drop[1]);
      check("seq_gap_b", int'(gap_b), m_gap[1]);
      check("underrun_b", int'(under_b), m_under[1]);
      check("overflow_b", int'(ovf_b), m_ovf[1]);
      check("level_b", int'(lvl_b), msize(1));
      check("playing_b", int'(play_b), m_play[1]);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_ok"}, int'(ok_a), 0);
    check({tag, "_drop"}, int'(drop_a), 0);
    check({tag, "_gap"}, int'(gap_a), 0);
    check({tag, "_under"}, int'(under_a), 0);
    check({tag, "_ovf"}, int'(ovf_a), 0);
    check({tag, "_level"}, int'(lvl_a), 0);
    check({tag, "_playing"}, int'(play_a), 0);
    check({tag, "_wav_out"}, int'(if_a.wav_out_data), 0);
  endtask

  // Run-time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    if_a.udp_rec_data_length = '0;
    if_b.udp_rec_data_length = '0;
    if_a.wav_rden = 1'b1;
    if_b.wav_rden = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_a("reset");

    // Read request present as reset is released, FIFO empty.
    rst_n = 1'b1;
    @(posedge clk); #1;
    if_a.wav_rden = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("exit_underrun", int'(under_a), 1);
    check_status(0);

    // Small FIFO: 20 samples into 16 slots.
    build(1, 32'h12345678, 20, 0, 0);
    send(1, 1'b0);
    check("small_level", int'(lvl_b), 16);
    check("small_ovf", int'(ovf_b), 4);
    check("small_playing", int'(play_b), 1);
    check_status(1);
    reads(1, 16);
    check("small_drained", int'(lvl_b), 0);
    check_status(1);

    // Full 480-sample packet primes playback.
    build(5, 32'h12345678, 480, 0, 0);
    send(0, 1'b0);
    check("t1_ok", int'(ok_a), 1);
    check("t1_level", int'(lvl_a), 480);
    check("t1_playing", int'(play_a), 1);
    check_status(0);

    // Wrong SSRC is dropped, the following packet is realigned.
    build(6, 32'h12345679, 480, 16'h2000, 0);
    send(0, 1'b0);
    check("t2_drop", int'(drop_a), 1);
    check("t2_level", int'(lvl_a), 480);
    build(6, 32'h12345678, 4, 16'h1000, 0);
    send(0, 1'b0);
    check("t2_level_after", int'(lvl_a), 484);
    check_status(0);

    // Sequence discontinuities including the 16-bit wrap.
    begin
      int seqs[5] = '{7, 8, 10, 16'hFFFF, 0};
      for (int k = 0; k < 5; k++) begin
        build(seqs[k], 32'h12345678, 1, 16'h3000 + k, 0);
        send(0, 1'b0);
      end
    end
    check("t3_gap", int'(gap_a), 2);
    check("t3_ok", int'(ok_a), 7);
    check_status(0);

    // Drain everything, then one read past empty.
    reads(0, 3);
    check("t4_third_sample", int'(if_a.wav_out_data), 16'h0002);
    reads(0, 487);
    check("t4_underrun", int'(under_a), 2);
    check("t4_playing", int'(play_a), 0);
    check("t4_level", int'(lvl_a), 0);
    check_status(0);

    // Odd-length packet with gapped valid.
    build(1, 32'h12345678, 1, 16'hABCD, 1);
    send(0, 1'b1);
    check("t6_ok", int'(ok_a), 8);
    check("t6_level", int'(lvl_a), 1);
    check_status(0);

    // Too-short packet.
    pkt.delete();
    pkt.push_back(8'h80); pkt.push_back(8'h80); pkt.push_back(8'h00);
    pkt.push_back(8'h02); pkt.push_back(8'h00);
    send(0, 1'b0);
    check("t6_short_drop", int'(drop_a), 2);
    check_status(0);

    // Reset in the middle of a payload.
    build(2, 32'h12345678, 480, 0, 0);
    send_bytes(0, 1'b0, 100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    check_zero_a("midrst");

    // Clean packet after reset.
    build(16'h55, 32'h12345678, 2, 16'h4444, 0);
    send(0, 1'b0);
    check("post_rst_ok", int'(ok_a), 1);
    check("post_rst_level", int'(lvl_a), 2);
    check_status(0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtp_audio_depacketizer.md
Name: rtp_audio_depacketizer

Overview:
Receive-side counterpart of the RTP audio packetizer. Parses UDP payload bytes from the Ethernet receive path, validates the RTP header, and unpacks big-endian 16-bit PCM samples into a jitter FIFO. The FIFO is drained by the codec playback path through the wav_rden / wav_out_data interface. Sits between the UDP receive port of the Ethernet block and the play side of the WM8731 wav controller, all on the 50 MHz clk.

Parameters:
RTP_HEADER, 16'h8080, required value of RTP bytes 0-1 (V/P/X/CC, M/PT).
SSRC, 32'h12345678, required SSRC in RTP bytes 8-11.
FIFO_AW, 10, sample FIFO address width; depth 2^FIFO_AW samples.
PREFILL, 480, FIFO level (in samples) required before playback starts.

Ports:
clk  in  1  system clock, 50 MHz.
rst_n  in  1  synchronous active-low reset.
udp_rec_data_valid  in  1  qualifies udp_rec_rdata; one byte per high cycle; gaps allowed.
udp_rec_rdata  in  8  UDP payload byte, RTP header first.
udp_rec_data_length  in  16  UDP payload length in bytes; stable from the first byte of a packet.
wav_rden  in  1  playback requests one sample.
wav_out_data  out  16  sample returned for the last wav_rden.
playing  out  1  jitter buffer primed; samples are being released.
fifo_level  out  FIFO_AW+1  current sample count.
pkt_ok_cnt  out  16  accepted packets.
pkt_drop_cnt  out  16  rejected packets.
seq_gap_cnt  out  16  sequence discontinuities.
underrun_cnt  out  16  wav_rden while not playing or FIFO empty.
overflow_cnt  out  16  samples discarded because the FIFO was full.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, FIFO empty, FSM IDLE, seq_valid=0. Reset mid-packet abandons the packet; the remaining bytes of it are not resynchronised (the source must be idle when reset is released).
- FSM states: IDLE, HDR, PAYLOAD, DROP. A byte counter bcnt counts valid bytes only.
- IDLE: on the first valid byte, latch len = udp_rec_data_length and set bcnt=1.
  - len < 12 -> DROP (or straight to IDLE when len <= 1).
  - Otherwise -> HDR, with byte 0 checked against RTP_HEADER[15:8].
- HDR: check byte 1 against RTP_HEADER[7:0], capture bytes 2-3 as seq, ignore bytes 4-7 (timestamp), check bytes 8-11 against SSRC.
  - Any mismatch -> DROP immediately and pkt_drop_cnt++.
  - After byte 11: if len == 12 go to IDLE, otherwise go to PAYLOAD.
  - On each accepted header, evaluate the sequence: if seq_valid and seq != exp_seq, seq_gap_cnt++. Then exp_seq = seq+1 (16-bit wrap, so FFFF -> 0000 is not a gap) and seq_valid=1.
- PAYLOAD: even payload bytes are the sample MSB (held); odd bytes complete the sample {msb, byte}, which is pushed to the FIFO the cycle after it completes.
  - Push while full: discard the sample and increment overflow_cnt.
  - When bcnt reaches len: go to IDLE and increment pkt_ok_cnt. A trailing odd byte is silently discarded.
- DROP: consume bytes until bcnt == len, then go to IDLE.
- Counters saturate at 16'hFFFF.
- Playout:
  - playing rises when fifo_level >= PREFILL.
  - wav_rden with playing=1 and FIFO non-empty: pop; wav_out_data updates exactly 1 cycle after wav_rden.
  - wav_rden while not playing or FIFO empty: wav_out_data = 16'h0000 one cycle later and underrun_cnt++.
  - An empty-FIFO read clears playing; it re-arms only at the PREFILL level.
  - With no wav_rden, wav_out_data holds its value.
- A simultaneous push and pop leaves fifo_level unchanged. Pointers wrap modulo 2^FIFO_AW; the level is computed from pointers that are 1 bit wider.

Decomposition:
- Shared package rtp_pkg: RTP_HDR_BYTES=12, header byte offsets (SEQ_HI=2, SEQ_LO=3, SSRC0=8), FSM state enum, and the default RTP_HEADER/SSRC constants shared with the packetizer.
- One sub-module, sample_fifo: synchronous single-clock FIFO, 16-bit wide, 2^FIFO_AW deep, with full, empty and level outputs and inferred RAM.

Test Plan:
1. Send a packet with len=972: header 80 80 0005 ts 12345678, then 480 samples 0x0000..0x01DF. Expect pkt_ok_cnt=1, fifo_level=480, playing=1. 480 wav_rden reads return 0x0000..0x01DF in order, each 1 cycle later.
2. Bad SSRC 0x12345679 at len=972. Expect pkt_drop_cnt=1, fifo_level unchanged. The next good packet is accepted with correct byte alignment.
3. Sequences 7, 8, 10, then 0xFFFF followed by 0x0000. Expect seq_gap_cnt=2 in total: one for 8->10 and one for 10->0xFFFF; the 0xFFFF->0x0000 wrap adds no gap.
4. wav_rden asserted at reset exit with an empty FIFO. Expect wav_out_data=0 and underrun_cnt=1. Then drain to empty and read once more: playing drops and underrun_cnt increments.
5. FIFO_AW=4, PREFILL=8: a 20-sample packet with no reads. Expect fifo_level=16 and overflow_cnt=4; reads return samples 0..15.
6. len=15 (one odd trailing byte), with valid toggling 1/0 on every byte. Expect 1 sample pushed and pkt_ok_cnt=1. Also: len=5 -> drop; assert rst_n low mid-payload -> all counters 0 and FIFO empty.
